// File: rtl/bomb_ctrl.sv
// bomb_ctrl: single-bomb lifecycle controller (place, fuse, blast, cooldown).
// Latches a tile-snapped position and emits one explosion strobe per bomb.
module bomb_ctrl #(
  parameter int FUSE_TICKS     = 180,
  parameter int BLAST_TICKS    = 30,
  parameter int COOLDOWN_TICKS = 15,
  parameter int BLINK_TICKS    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       place_btn,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  output logic       bomb_active,
  output logic       bomb_blink,
  output logic [9:0] bomb_x,
  output logic [9:0] bomb_y,
  output logic       explosion_SCEN,
  output logic       explosion_active,
  output logic [9:0] e_x,
  output logic [9:0] e_y,
  output logic       busy
);

  localparam int M1 =
    (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int MAXT =
    (M1 > COOLDOWN_TICKS) ? M1 : COOLDOWN_TICKS;
  localparam int CW = $clog2(MAXT) + 1;
  localparam int BW = $clog2(BLINK_TICKS) + 1;

  localparam logic [CW-1:0] FUSE_LAST  = CW'(FUSE_TICKS - 1);
  localparam logic [CW-1:0] BLAST_LAST = CW'(BLAST_TICKS - 1);
  localparam logic [CW-1:0] CD_LAST    =
    (COOLDOWN_TICKS == 0) ? '0 : CW'(COOLDOWN_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    BLAST,
    COOL
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] blk_cnt, blk_cnt_nx;
  logic          blink, blink_nx;
  logic          scen_nx;
  logic          btn_q;
  logic          press;
  logic [9:0]    bx_nx, by_nx, ex_nx, ey_nx;

  // Round to the nearest 16-px tile, clamped to the last on-field tile.
  function automatic logic [9:0] snap(input logic [9:0] p);
    logic [10:0] s;
    s = {1'b0, p} + 11'd8;
    s[3:0] = 4'd0;
    if (s > 11'd1008) s = 11'd1008;
    return s[9:0];
  endfunction

  assign press = place_btn & ~btn_q;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    blk_cnt_nx = blk_cnt;
    blink_nx   = blink;
    scen_nx    = 1'b0;
    bx_nx      = bomb_x;
    by_nx      = bomb_y;
    ex_nx      = e_x;
    ey_nx      = e_y;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_nx   = ARMED;
          cnt_nx     = '0;
          blk_cnt_nx = '0;
          blink_nx   = 1'b1;
          bx_nx      = snap(b_x);
          by_nx      = snap(b_y);
        end
      end
      ARMED: begin
        if (tick) begin
          if (cnt == FUSE_LAST) begin
            state_nx   = BLAST;
            cnt_nx     = '0;
            blk_cnt_nx = '0;
            blink_nx   = 1'b0;
            scen_nx    = 1'b1;
            ex_nx      = bomb_x;
            ey_nx      = bomb_y;
          end else begin
            cnt_nx = cnt + CW'(1);
            if (blk_cnt == BLINK_LAST) begin
              blk_cnt_nx = '0;
              blink_nx   = ~blink;
            end else begin
              blk_cnt_nx = blk_cnt + BW'(1);
            end
          end
        end
      end
      BLAST: begin
        if (tick) begin
          if (cnt == BLAST_LAST) begin
            cnt_nx   = '0;
            state_nx = (COOLDOWN_TICKS == 0) ? IDLE : COOL;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      COOL: begin
        if (tick) begin
          if (cnt == CD_LAST) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      blk_cnt        <= '0;
      blink          <= 1'b0;
      explosion_SCEN <= 1'b0;
      btn_q          <= 1'b1;
      bomb_x         <= '0;
      bomb_y         <= '0;
      e_x            <= '0;
      e_y            <= '0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      blk_cnt        <= blk_cnt_nx;
      blink          <= blink_nx;
      explosion_SCEN <= scen_nx;
      btn_q          <= place_btn;
      bomb_x         <= bx_nx;
      bomb_y         <= by_nx;
      e_x            <= ex_nx;
      e_y            <= ey_nx;
    end
  end

  assign bomb_active      = (state == ARMED);
  assign bomb_blink       = blink;
  assign explosion_active = (state == BLAST);
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_bomb_ctrl.sv
// tb_bomb_ctrl: directed vector table plus hand-written lifecycle sequences.
// Runs with FUSE=4, BLAST=2, COOLDOWN=1, BLINK=2.
module tb_bomb_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       place_btn = 1'b0;
  logic [9:0] b_x = '0;
  logic [9:0] b_y = '0;
  logic       bomb_active, bomb_blink;
  logic [9:0] bomb_x, bomb_y, e_x, e_y;
  logic       explosion_SCEN, explosion_active, busy;

  int n_chk = 0;
  int n_fail = 0;
  int scen_cnt = 0;

  bomb_ctrl #(
    .FUSE_TICKS    (4),
    .BLAST_TICKS   (2),
    .COOLDOWN_TICKS(1),
    .BLINK_TICKS   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .place_btn       (place_btn),
    .b_x             (b_x),
    .b_y             (b_y),
    .bomb_active     (bomb_active),
    .bomb_blink      (bomb_blink),
    .bomb_x          (bomb_x),
    .bomb_y          (bomb_y),
    .explosion_SCEN  (explosion_SCEN),
    .explosion_active(explosion_active),
    .e_x             (e_x),
    .e_y             (e_y),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (explosion_SCEN) scen_cnt++;

  typedef struct {
    logic       btn, tk;
    logic [9:0] bx, by;
    logic       act, blk, scen, eact, bsy;
    logic [9:0] box, boy, ex, ey;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(
    input int btn, tk, bx, by,
    input int act, blk, scen, eact, bsy,
    input int box, boy, ex, ey);
    vec_t v;
    v.btn = btn[0]; v.tk = tk[0];
    v.bx = bx[9:0]; v.by = by[9:0];
    v.act = act[0]; v.blk = blk[0];
    v.scen = scen[0]; v.eact = eact[0];
    v.bsy = bsy[0];
    v.box = box[9:0]; v.boy = boy[9:0];
    v.ex = ex[9:0]; v.ey = ey[9:0];
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic btn, input logic tk);
    place_btn = btn;
    tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " act"}, 32'(bomb_active), 0);
    chk({tag, " blink"}, 32'(bomb_blink), 0);
    chk({tag, " scen"}, 32'(explosion_SCEN), 0);
    chk({tag, " eact"}, 32'(explosion_active), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " bomb_x"}, 32'(bomb_x), 0);
    chk({tag, " bomb_y"}, 32'(bomb_y), 0);
    chk({tag, " e_x"}, 32'(e_x), 0);
    chk({tag, " e_y"}, 32'(e_y), 0);
  endtask

  initial begin
    int s0;
    logic flag;
    //         btn tk  bx   by  act blk scn eac bsy box  boy  ex  ey
    vt[0]  = mk(0, 0, 307, 100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 307, 100, 1, 1, 0, 0, 1, 304, 96, 0, 0);
    vt[2]  = mk(0, 1, 500, 500, 1, 1, 0, 0, 1, 304, 96, 0, 0);
    vt[3]  = mk(1, 0, 500, 500, 1, 1, 0, 0, 1, 304, 96, 0, 0);
    vt[4]  = mk(0, 1, 500, 500, 1, 0, 0, 0, 1, 304, 96, 0, 0);
    vt[5]  = mk(1, 0, 500, 500, 1, 0, 0, 0, 1, 304, 96, 0, 0);
    vt[6]  = mk(1, 1, 500, 500, 1, 0, 0, 0, 1, 304, 96, 0, 0);
    vt[7]  = mk(0, 0, 500, 500, 1, 0, 0, 0, 1, 304, 96, 0, 0);
    vt[8]  = mk(0, 1, 500, 500, 0, 0, 1, 1, 1, 304, 96, 304, 96);
    vt[9]  = mk(1, 0, 500, 500, 0, 0, 0, 1, 1, 304, 96, 304, 96);
    vt[10] = mk(0, 1, 500, 500, 0, 0, 0, 1, 1, 304, 96, 304, 96);
    vt[11] = mk(0, 1, 500, 500, 0, 0, 0, 0, 1, 304, 96, 304, 96);
    vt[12] = mk(1, 0, 500, 500, 0, 0, 0, 0, 1, 304, 96, 304, 96);
    vt[13] = mk(0, 1, 500, 500, 0, 0, 0, 0, 0, 304, 96, 304, 96);
    vt[14] = mk(1, 0, 1020, 1023, 1, 1, 0, 0, 1, 1008, 1008, 304, 96);
    vt[15] = mk(0, 1, 1020, 1023, 1, 1, 0, 0, 1, 1008, 1008, 304, 96);

    // Reset state
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Vector table: lifecycle, ignored presses, snap and clamp
    s0 = scen_cnt;
    foreach (vt[i]) begin
      b_x = vt[i].bx;
      b_y = vt[i].by;
      cyc(vt[i].btn, vt[i].tk);
      chk($sformatf("v%0d act", i), 32'(bomb_active), 32'(vt[i].act));
      chk($sformatf("v%0d blink", i), 32'(bomb_blink), 32'(vt[i].blk));
      chk($sformatf("v%0d scen", i), 32'(explosion_SCEN), 32'(vt[i].scen));
      chk($sformatf("v%0d eact", i), 32'(explosion_active), 32'(vt[i].eact));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].bsy));
      chk($sformatf("v%0d bomb_x", i), 32'(bomb_x), 32'(vt[i].box));
      chk($sformatf("v%0d bomb_y", i), 32'(bomb_y), 32'(vt[i].boy));
      chk($sformatf("v%0d e_x", i), 32'(e_x), 32'(vt[i].ex));
      chk($sformatf("v%0d e_y", i), 32'(e_y), 32'(vt[i].ey));
    end
    chk("table scen pulses", 32'(scen_cnt - s0), 1);

    // Button held through reset never places
    place_btn = 1'b1;
    reset = 1'b1;
    #1;
    chk_zero("reset2");
    @(posedge clk);
    #1 reset = 1'b0;
    b_x = 10'd200;
    b_y = 10'd33;
    flag = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, (k % 4) == 3);
      flag |= busy | bomb_active;
    end
    chk("held no place", 32'(flag), 0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("held then press act", 32'(bomb_active), 1);
    chk("held then press bomb_x", 32'(bomb_x), 208);
    chk("held then press bomb_y", 32'(bomb_y), 32);

    // Reset mid-fuse after two ticks
    s0 = scen_cnt;
    for (int k = 0; k < 8; k++) cyc(1'b0, (k % 4) == 3);
    chk("mid-fuse still armed", 32'(bomb_active), 1);
    #2 reset = 1'b1;
    #1;
    chk_zero("async reset");
    @(posedge clk);
    #1 reset = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 80; k++) begin
      cyc(1'b0, (k % 4) == 3);
      flag |= busy | bomb_active | explosion_active;
    end
    chk("aborted bomb scen", 32'(scen_cnt - s0), 0);
    chk("aborted bomb idle", 32'(flag), 0);

    // Press and tick together, then full lifecycle at tick-every-4th
    s0 = scen_cnt;
    b_x = 10'd40;
    b_y = 10'd17;
    cyc(1'b1, 1'b1);
    chk("coinc act", 32'(bomb_active), 1);
    chk("coinc blink", 32'(bomb_blink), 1);
    b_x = 10'd999;
    for (int t = 1; t <= 4; t++) begin
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
      chk($sformatf("pre t%0d act", t), 32'(bomb_active), 1);
      chk($sformatf("pre t%0d scen", t), 32'(explosion_SCEN), 0);
      cyc(1'b0, 1'b1);
      if (t < 4) begin
        chk($sformatf("t%0d act", t), 32'(bomb_active), 1);
        chk($sformatf("t%0d blink", t), 32'(bomb_blink),
            (t == 1) ? 1 : 0);
      end
    end
    chk("det scen", 32'(explosion_SCEN), 1);
    chk("det eact", 32'(explosion_active), 1);
    chk("det act", 32'(bomb_active), 0);
    chk("det e_x", 32'(e_x), 48);
    chk("det e_y", 32'(e_y), 16);
    cyc(1'b0, 1'b0);
    chk("det+1 scen", 32'(explosion_SCEN), 0);
    chk("det+1 eact", 32'(explosion_active), 1);
    repeat (2) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("blast t1 eact", 32'(explosion_active), 1);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("blast t2 eact", 32'(explosion_active), 0);
    chk("cooldown busy", 32'(busy), 1);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("idle busy", 32'(busy), 0);
    chk("idle e_x hold", 32'(e_x), 48);
    chk("coinc scen pulses", 32'(scen_cnt - s0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bomb_ctrl.md
# bomb_ctrl

Single-bomb lifecycle controller for the play field. It latches a tile-aligned bomb position from the bomberman location when the player presses place, and counts a fuse in frame ticks. It then fires the one-cycle `explosion_SCEN` pulse and explosion coordinates consumed by the box/wall logic, holds the blast visible, and enforces a cooldown before another bomb can be placed. It sits between the input/movement logic and the box datapath and sequences every explosion the box logic sees.

## Interface
- `FUSE_TICKS`, 180, frame ticks from placement to detonation (≥1)
- `BLAST_TICKS`, 30, frame ticks the explosion stays displayed (≥1)
- `COOLDOWN_TICKS`, 15, frame ticks after blast before next placement (≥0)
- `BLINK_TICKS`, 8, frame ticks per bomb-sprite blink half-period (≥1)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `tick`  in  1  one-cycle frame-rate enable (e.g. 60 Hz)
- `place_btn`  in  1  debounced place-bomb button, level
- `b_x`, `b_y`  in  10 each  bomberman top-left pixel
- `bomb_active`  out  1  bomb sprite on field (ARMED)
- `bomb_blink`  out  1  bomb sprite visible phase
- `bomb_x`, `bomb_y`  out  10 each  latched bomb tile top-left
- `explosion_SCEN`  out  1  single-cycle detonation pulse
- `explosion_active`  out  1  blast sprite displayed (BLAST)
- `e_x`, `e_y`  out  10 each  explosion centre tile top-left
- `busy`  out  1  high in any state except IDLE

## Operation
- States: IDLE, ARMED, BLAST, COOLDOWN.
- Press detect: `press = place_btn & ~btn_q`. `btn_q` is a registered copy of `place_btn` and resets to 1, so a button held through reset never places a bomb.
- Tile snap: `bomb_x = ((b_x + 8) >> 4) << 4`, computed in 11 bits. If the result exceeds 1008, clamp to 1008. The same rule applies to `bomb_y`. This rounds to the nearest 16-px tile.
- IDLE: on `press`, latch the snapped `bomb_x`/`bomb_y`, load tick counter = 0, set blink = 1, and go to ARMED.
- ARMED: each `tick` increments the counter. Every `BLINK_TICKS` ticks, blink toggles. On the tick that brings the counter to `FUSE_TICKS`, clear the counter and go to BLAST.
- BLAST: `explosion_SCEN` = 1 on the first cycle in BLAST only. `e_x`/`e_y` = latched bomb position throughout BLAST. The counter runs on ticks. After `BLAST_TICKS` ticks, go to COOLDOWN, or straight to IDLE when `COOLDOWN_TICKS` = 0.
- COOLDOWN: count `COOLDOWN_TICKS` ticks, then go to IDLE.
- `press` outside IDLE is ignored, not queued. A new press requires a fresh rising edge after returning to IDLE.
- `b_x`/`b_y` changes after latching do not affect `bomb_x`/`bomb_y`/`e_x`/`e_y`.
- Counter width is `$clog2` of the max tick parameter + 1. It never wraps, because it is cleared on each state exit.

## Timing
- Reset values: state IDLE. `bomb_active`, `bomb_blink`, `explosion_SCEN`, `explosion_active`, and `busy` = 0. `bomb_x`, `bomb_y`, `e_x`, `e_y` = 0. Counter = 0, `btn_q` = 1.
- All outputs are registered, with no combinational path from inputs.
- Press latency: for `press` at cycle N, `bomb_active`, `busy`, and `bomb_x`/`bomb_y` are valid at N+1.
- Detonation: if the final fuse tick is at cycle M, `explosion_SCEN` = 1 and `explosion_active` = 1 at M+1. `explosion_SCEN` = 0 at M+2. `bomb_active` = 0 at M+1.
- `e_x`/`e_y` are stable from M+1 for the entire BLAST state. They hold their value afterwards, but are meaningful only while `explosion_active` = 1.
- `press` and `tick` in the same IDLE cycle: the press is accepted and that tick is not counted. The fuse counts from later ticks only.
- `tick` in the same cycle as the IDLE→ARMED transition register update: not counted, as above.
- Reset mid-ARMED/BLAST: all outputs return to reset values asynchronously. No `explosion_SCEN` is emitted for the aborted bomb.
- `tick` held high continuously: each cycle counts as one tick.

## Test plan
Params for all scenarios: FUSE=4, BLAST=2, COOLDOWN=1, BLINK=2, `tick` every 4th clock.

1. Snap: `b_x`=307, `b_y`=100, press → `bomb_x`=304, `bomb_y`=96 one cycle later. `b_x`=1020 → `bomb_x`=1008 (clamp).
2. Full lifecycle: press, then count ticks → `bomb_active` for exactly 4 ticks. `explosion_SCEN` high for exactly 1 clock, the clock after the 4th tick, with `e_x`/`e_y` equal to the latched position. `explosion_active` lasts 2 ticks, `busy` falls 1 tick later.
3. Ignored presses: extra rising edges during ARMED/BLAST/COOLDOWN → `bomb_x` unchanged, exactly one `explosion_SCEN`. A press after `busy` falls → new bomb.
4. Held button: `place_btn` held from reset deassertion → no placement. Release then press → placement.
5. Reset mid-fuse after 2 ticks → all outputs 0 immediately, no `explosion_SCEN` within 20 subsequent ticks.
6. Blink and coincident events: `bomb_blink` toggles every 2 ticks starting at 1. Press and tick in the same cycle → detonation after 4 further ticks.
